// File: rtl/ram_arb_pkg.sv
// Shared constants and state encoding for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned ADR_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = PTR_W'((32'(ptr) + off) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one synchronous RAM port among NREQ requesters: optional zero sweep after
// reset, then one round-robin grant per cycle with tagged one-cycle-later read return.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned ADR_W          = ram_arb_pkg::ADR_W,
  parameter int unsigned DATA_W         = ram_arb_pkg::DATA_W,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NREQ-1:0]          Req,
  input  logic [NREQ-1:0]          We,
  input  logic [NREQ*ADR_W-1:0]    ReqAdr,
  input  logic [NREQ*DATA_W-1:0]   ReqData,
  output logic [NREQ-1:0]          Gnt,
  output logic [NREQ-1:0]          Rvalid,
  output logic [DATA_W-1:0]        Rdata,
  output logic                     Busy,
  output logic [DATA_W-1:0]        RamIbus,
  output logic [ADR_W-1:0]         RamAdr,
  output logic                     RamRead,
  input  logic [DATA_W-1:0]        RamObus
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [ADR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [NREQ-1:0]  rvalid_q, rvalid_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;

  logic [ADR_W-1:0]  req_adr  [NREQ];
  logic [DATA_W-1:0] req_data [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_adr[i]  = ReqAdr[i*ADR_W +: ADR_W];
    assign req_data[i] = ReqData[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req (Req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    clr_cnt_d = clr_cnt_q;
    rvalid_d  = '0;
    Gnt       = '0;
    Busy      = 1'b0;
    RamRead   = 1'b1;
    RamAdr    = adr_q;
    RamIbus   = '0;

    if (Rst) begin
      Busy   = 1'b1;
      RamAdr = '0;
    end else if (state_q == CLEAR) begin
      Busy      = 1'b1;
      RamRead   = 1'b0;
      RamAdr    = clr_cnt_q;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) begin
        state_d = SERVE;
      end
    end else if (win_any) begin
      Gnt               = arb_gnt;
      RamAdr            = req_adr[win_idx];
      RamRead           = ~We[win_idx];
      RamIbus           = We[win_idx] ? req_data[win_idx] : '0;
      rvalid_d[win_idx] = ~We[win_idx];
      ptr_d             = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // Idle cycles re-drive the last address, so the held value is simply what went out.
    adr_d = RamAdr;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : SERVE;
      ptr_q     <= '0;
      clr_cnt_q <= '0;
      adr_q     <= '0;
      rvalid_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      clr_cnt_q <= clr_cnt_d;
      adr_q     <= adr_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // A read granted just before reset must not surface during the reset cycle.
  assign Rvalid = Rst ? '0 : rvalid_q;
  assign Rdata  = RamObus;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 16x8 synchronous RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        Rst;
  logic [1:0]  Req, We;
  logic [7:0]  ReqAdr;
  logic [15:0] ReqData;
  logic [1:0]  Gnt, Rvalid;
  logic [7:0]  Rdata;
  logic        Busy;
  logic [7:0]  RamIbus;
  logic [3:0]  RamAdr;
  logic        RamRead;
  logic [7:0]  RamObus;

  logic [7:0] mem [16] = '{default: 8'hEE};
  int         wr_count = 0;
  int         wr_base;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NREQ           (2),
    .ADR_W          (4),
    .DATA_W         (8),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .Clk     (clk),
    .Rst     (Rst),
    .Req     (Req),
    .We      (We),
    .ReqAdr  (ReqAdr),
    .ReqData (ReqData),
    .Gnt     (Gnt),
    .Rvalid  (Rvalid),
    .Rdata   (Rdata),
    .Busy    (Busy),
    .RamIbus (RamIbus),
    .RamAdr  (RamAdr),
    .RamRead (RamRead),
    .RamObus (RamObus)
  );

  always @(posedge clk) begin
    if (RamRead) begin
      RamObus <= mem[RamAdr];
    end else begin
      mem[RamAdr] <= RamIbus;
      wr_count    <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] we,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    Req     = req;
    We      = we;
    ReqAdr  = {a1, a0};
    ReqData = {d1, d0};
  endtask

  initial begin
    Rst = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    repeat (2) next_cycle();
    check("rst_busy", Busy, 1);
    check("rst_gnt", Gnt, 0);
    check("rst_rvalid", Rvalid, 0);
    check("rst_read", RamRead, 1);
    check("rst_adr", RamAdr, 0);
    check("rst_ibus", RamIbus, 0);

    // Release reset; requester 0 asks to read address 9 while the sweep runs.
    Rst     = 1'b0;
    wr_base = wr_count;
    drive(2'b01, 2'b00, 4'd9, 4'd0, 8'h00, 8'h00);
    #1;
    for (int i = 0; i < 16; i++) begin
      check("clr_adr", RamAdr, i);
      check("clr_read", RamRead, 0);
      check("clr_ibus", RamIbus, 0);
      check("clr_busy", Busy, 1);
      check("clr_gnt", Gnt, 0);
      next_cycle();
    end
    check("serve_busy", Busy, 0);
    check("clr_writes", wr_count - wr_base, 16);
    check("pend_gnt", Gnt, 2'b01);
    check("pend_read", RamRead, 1);
    check("pend_adr", RamAdr, 9);
    for (int i = 0; i < 16; i++) check("clr_mem", mem[i], 0);

    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("rd9_rvalid", Rvalid, 2'b01);
    check("rd9_rdata", Rdata, 8'h00);
    check("idle_gnt", Gnt, 0);
    check("idle_read", RamRead, 1);
    check("idle_adr_hold", RamAdr, 9);

    // Requester 0 alone: write 0xA5 to 3, read it back.
    next_cycle();
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    #1;
    check("wr3_gnt", Gnt, 2'b01);
    check("wr3_read", RamRead, 0);
    check("wr3_adr", RamAdr, 3);
    check("wr3_ibus", RamIbus, 8'hA5);
    next_cycle();
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    check("rd3_gnt", Gnt, 2'b01);
    check("rd3_read", RamRead, 1);
    check("rd3_ibus", RamIbus, 0);
    check("wr_no_rvalid", Rvalid, 0);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("rd3_rvalid", Rvalid, 2'b01);
    check("rd3_rdata", Rdata, 8'hA5);

    // Preload 1 <- 0x11 (req0) and 2 <- 0x22 (req1); pointer ends back at 0.
    next_cycle();
    drive(2'b01, 2'b01, 4'd1, 4'd0, 8'h11, 8'h00);
    #1;
    check("pre1_gnt", Gnt, 2'b01);
    next_cycle();
    drive(2'b10, 2'b10, 4'd0, 4'd2, 8'h00, 8'h22);
    #1;
    check("pre2_gnt", Gnt, 2'b10);
    check("pre2_ibus", RamIbus, 8'h22);

    next_cycle();
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    #1;
    for (int c = 0; c < 4; c++) begin
      check("rr_gnt", Gnt, (c % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_adr", RamAdr, (c % 2 == 0) ? 1 : 2);
      if (c == 0) begin
        check("rr_rvalid0", Rvalid, 0);
      end else begin
        check("rr_rvalid", Rvalid, (c % 2 == 1) ? 2'b01 : 2'b10);
        check("rr_rdata", Rdata, (c % 2 == 1) ? 8'h11 : 8'h22);
      end
      next_cycle();
    end
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("rr_rvalid_last", Rvalid, 2'b10);
    check("rr_rdata_last", Rdata, 8'h22);

    // Requester 1 writes 0x5A to 7, requester 0 reads 7 next cycle.
    next_cycle();
    drive(2'b10, 2'b10, 4'd0, 4'd7, 8'h00, 8'h5A);
    #1;
    check("wr7_gnt", Gnt, 2'b10);
    check("wr7_adr", RamAdr, 7);
    check("wr7_ibus", RamIbus, 8'h5A);
    next_cycle();
    drive(2'b01, 2'b00, 4'd7, 4'd0, 8'h00, 8'h00);
    #1;
    check("rd7_gnt", Gnt, 2'b01);
    check("rd7_read", RamRead, 1);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("rd7_rvalid", Rvalid, 2'b01);
    check("rd7_rdata", Rdata, 8'h5A);

    // Read granted, reset next cycle: its Rvalid is suppressed and the sweep restarts.
    next_cycle();
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    #1;
    check("rdr_gnt", Gnt, 2'b01);
    next_cycle();
    Rst = 1'b1;
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("rdr_rvalid", Rvalid, 0);
    check("rdr_busy", Busy, 1);
    check("rdr_read", RamRead, 1);
    next_cycle();
    Rst = 1'b0;
    #1;
    check("swp_adr0", RamAdr, 0);
    check("swp_read0", RamRead, 0);
    check("swp_busy", Busy, 1);
    next_cycle();
    check("swp_adr1", RamAdr, 1);
    next_cycle();
    check("swp_adr2", RamAdr, 2);

    // Reset during the sweep restarts it from address 0.
    Rst = 1'b1;
    #1;
    check("midclr_rst_adr", RamAdr, 0);
    check("midclr_rst_read", RamRead, 1);
    next_cycle();
    Rst = 1'b0;
    #1;
    check("restart_adr", RamAdr, 0);
    check("restart_read", RamRead, 0);
    repeat (15) next_cycle();
    check("restart_last_adr", RamAdr, 15);
    check("restart_last_busy", Busy, 1);
    next_cycle();
    check("restart_done_busy", Busy, 0);
    check("restart_idle_gnt", Gnt, 0);

    // Pointer was reset to 0, so requester 0 wins a tie.
    drive(2'b11, 2'b00, 4'd1, 4'd2, 8'h00, 8'h00);
    #1;
    check("ptr_rst_gnt", Gnt, 2'b01);
    next_cycle();
    drive(2'b00, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    #1;
    check("ptr_rst_rvalid", Rvalid, 2'b01);
    check("ptr_rst_rdata", Rdata, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
